// File: rtl/fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_out
// Brief    : FIFO read stage with a small prefetch buffer, presenting the FIFO
//            contents as a valid/ready stream.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_out #(
  parameter int SIZE_DATA = 8,
  parameter int BUF_DEPTH = 3,
  parameter int SIZE_CNT  = $clog2(BUF_DEPTH + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_fifo_rd_en,
  input  logic                 i_flush,
  output logic                 o_valid,
  output logic [SIZE_DATA-1:0] o_data,
  input  logic                 i_ready,
  output logic [SIZE_CNT-1:0]  o_count
);

  localparam int                 c_PTR_W = $clog2(BUF_DEPTH);
  localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(BUF_DEPTH - 1);

  logic [SIZE_DATA-1:0] r_buf [BUF_DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [SIZE_CNT-1:0]  r_occ;
  logic                 r_inflight;

  logic                 w_pop;
  logic                 w_capture;
  logic [SIZE_CNT:0]    w_pending;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Read issue counts the word already in flight so the buffer can never overflow;
  // it depends only on registered state, never on i_ready.
  assign w_pending    = {1'b0, r_occ} + (SIZE_CNT + 1)'(r_inflight);
  assign o_fifo_rd_en = ~i_rst & ~i_flush & ~i_fifo_empty &
                        (w_pending < (SIZE_CNT + 1)'(BUF_DEPTH));

  assign w_capture = r_inflight;
  assign w_pop     = o_valid & i_ready;

  assign o_valid = (r_occ != '0);
  assign o_data  = r_buf[r_head];
  assign o_count = r_occ;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (i_flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_fifo_rd_en;
      if (w_capture) begin
        r_buf[r_tail] <= i_fifo_data;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + SIZE_CNT'(1);
        2'b01:   r_occ <= r_occ - SIZE_CNT'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire
